// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program-counter and instruction-fetch front end. Issues one
//             instruction-memory request at a time, keeps the returned word
//             in a single-entry IF/ID buffer and supports branch redirect,
//             hazard stall and decode backpressure.
//  Revision : 1.0 - initial release
//
//  Build option:
//    PC_FETCH_MISALIGN_TRAP_EN - when defined, a redirect whose target is not
//        word aligned raises fetch_misalign for one cycle and leaves pc
//        unchanged. When undefined, fetch_misalign is tied low and the
//        target's low two bits are ignored.
//
//  Ports:
//    clk            in   1   clock, rising edge
//    reset          in   1   asynchronous active-high reset
//    stall          in   1   hazard stall, blocks new issues only
//    branch_taken   in   1   one-cycle redirect request
//    branch_target  in   32  redirect address
//    imem_req       out  1   outstanding request (registered)
//    imem_addr      out  32  fetch address (current pc)
//    imem_ack       in   1   memory completion
//    imem_rdata     in   32  instruction word, valid with imem_ack
//    if_valid       out  1   IF/ID buffer holds a valid word
//    if_pc          out  32  address of the buffered word
//    if_instr       out  32  buffered word
//    if_ready       in   1   decode accepts the buffer
//    fetch_misalign out  1   misaligned-redirect pulse
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // nothing outstanding
        S_BUSY = 2'd1,   // outstanding, result will be kept
        S_DROP = 2'd2    // outstanding, result will be discarded
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic        w_space;
    logic [31:0] w_redirect_pc;

    // Buffer can accept a word this cycle: empty, or being drained now.
    assign w_space = !r_if_valid || if_ready;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        r_fetch_misalign;
    logic        w_misalign;

    assign w_misalign     = (branch_target[1:0] != 2'b00);
    // A misaligned redirect flushes but keeps the old pc.
    assign w_redirect_pc  = w_misalign ? r_pc : branch_target;
    assign fetch_misalign = r_fetch_misalign;
`else
    assign w_redirect_pc  = branch_target & 32'hFFFF_FFFC;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_pc             <= RESET_PC;
            r_imem_req       <= 1'b0;
            r_if_valid       <= 1'b0;
            r_if_pc          <= 32'h0000_0000;
            r_if_instr       <= 32'h0000_0000;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            r_fetch_misalign <= 1'b0;
`endif
        end else if (branch_taken) begin
            // Redirect wins over stall, decode handshake and any ack.
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            r_fetch_misalign <= w_misalign;
`endif
            case (r_state)
                S_BUSY, S_DROP: begin
                    if (imem_ack) begin
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= S_DROP;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end else begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            r_fetch_misalign <= 1'b0;
`endif
            // Drain; a load below in the same cycle overrides this.
            if (r_if_valid && if_ready) begin
                r_if_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!stall && w_space) begin
                        r_state    <= S_BUSY;
                        r_imem_req <= 1'b1;
                    end
                end
                S_BUSY: begin
                    // Without buffer space the ack is not taken and the
                    // request stays outstanding.
                    if (imem_ack && w_space) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_instr <= imem_rdata;
                        r_pc       <= r_pc + 32'd4;
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Self-checking bench for pc_fetch_unit. Directed scenarios
//             followed by randomized traffic, all compared every cycle
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        fetch_misalign;

    int errors = 0;
    int checks = 0;

    // Reference model: "a request is in flight", "its word is unwanted",
    // plus the contents of the one-word decode buffer and the pc.
    bit          m_inflight;
    bit          m_unwanted;
    bit          m_full;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight  = 1'b0;
        m_unwanted  = 1'b0;
        m_full      = 1'b0;
        m_mis       = 1'b0;
        m_pc        = RESET_PC;
        m_buf_pc    = 32'h0;
        m_buf_instr = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_advance();
        bit can_take;
        bit bad;
        can_take = !m_full || if_ready;
        if (branch_taken) begin
            bad   = TRAP && (branch_target % 4 != 0);
            m_mis = bad;
            if (!bad) m_pc = branch_target - (branch_target % 4);
            m_full = 1'b0;
            if (m_inflight) begin
                if (imem_ack) begin
                    m_inflight = 1'b0;
                    m_unwanted = 1'b0;
                end else begin
                    m_unwanted = 1'b1;
                end
            end
        end else begin
            m_mis = 1'b0;
            if (m_full && if_ready) m_full = 1'b0;
            if (m_inflight) begin
                if (imem_ack && m_unwanted) begin
                    m_inflight = 1'b0;
                    m_unwanted = 1'b0;
                end else if (imem_ack && can_take) begin
                    m_full      = 1'b1;
                    m_buf_pc    = m_pc;
                    m_buf_instr = imem_rdata;
                    m_pc        = m_pc + 32'd4;
                    m_inflight  = 1'b0;
                end
            end else if (!stall && can_take) begin
                m_inflight = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_req",       imem_req,       m_inflight);
        check("imem_addr",      imem_addr,      m_pc);
        check("if_valid",       if_valid,       m_full);
        check("if_pc",          if_pc,          m_buf_pc);
        check("if_instr",       if_instr,       m_buf_instr);
        check("fetch_misalign", fetch_misalign, m_mis);
    endtask

    task automatic step(input bit st, input bit br, input logic [31:0] bt,
                        input bit rdy, input bit ack);
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        if_ready      = rdy;
        imem_ack      = ack;
        imem_rdata    = $urandom;
        model_advance();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] bt;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Straight-line fetch: one word every two cycles, 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 1, 0);
            check("seq_req", imem_req, 1'b1);
            step(0, 0, 32'h0, 1, 1);
            check("seq_valid", if_valid, 1'b1);
            check("seq_pc", if_pc, 32'(i * 4));
        end

        // Backpressure: buffer full, decode not ready; word must hold.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 32'h0, 0, 1);
            check("bp_req", imem_req, 1'b0);
            check("bp_pc", if_pc, 32'h8);
        end
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);
        check("bp_next_pc", if_pc, 32'hC);

        // Branch while a request to 0x10 is outstanding.
        step(0, 0, 32'h0, 1, 0);
        check("br_pending_addr", imem_addr, 32'h10);
        step(0, 1, 32'h200, 1, 0);
        check("br_drop_req", imem_req, 1'b1);
        step(0, 0, 32'h0, 1, 1);
        check("br_discard_valid", if_valid, 1'b0);
        check("br_new_addr", imem_addr, 32'h200);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);
        check("br_target_pc", if_pc, 32'h200);

        // Wrap at the top of the address space, then a 3-cycle stall.
        step(0, 1, 32'hFFFF_FFFC, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        check("wrap_issue_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1, 1);
        check("wrap_next_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0, 1, 0);
            check("stall_req", imem_req, 1'b0);
            check("stall_addr", imem_addr, 32'h0);
        end
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);

        // Misaligned redirect to 0x102 from pc 0x4.
        step(0, 1, 32'h102, 1, 0);
        check("mis_addr", imem_addr, TRAP ? 32'h4 : 32'h100);
        check("mis_flag", fetch_misalign, TRAP);
        step(0, 0, 32'h0, 1, 0);
        check("mis_pulse_end", fetch_misalign, 1'b0);

        // Reset in the middle of an outstanding request.
        check("rst_pre_req", imem_req, 1'b1);
        #2;
        reset    = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("rst_async_req", imem_req, 1'b0);
        check("rst_async_valid", if_valid, 1'b0);
        check("rst_async_addr", imem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        step(0, 0, 32'h0, 1, 0);
        check("rst_first_issue", imem_req, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bt = $urandom;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0,
                 bt,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
